// File: rtl/bay_billing_if.sv
// bay_billing_if: the bus between the bay sensors and pay terminal on one side
// and the billing arbiter on the other. The master drives the inputs and the
// slave (the arbiter) drives the bill/alarm/status outputs.
interface bay_billing_if #(
    parameter int BAYS  = 8,
    parameter int FEE_W = 12
);
    logic             en;
    logic             tick;
    logic [BAYS-1:0]  occ;
    logic             pay;
    logic             bill_valid;
    logic [2:0]       bill_bay;
    logic [FEE_W-1:0] bill_fee;
    logic             buz;
    logic [BAYS-1:0]  pending;
    logic [3:0]       free_cnt;

    modport master (
        output en, tick, occ, pay,
        input  bill_valid, bill_bay, bill_fee, buz, pending, free_cnt
    );

    modport slave (
        input  en, tick, occ, pay,
        output bill_valid, bill_bay, bill_fee, buz, pending, free_cnt
    );
endinterface

// File: rtl/bay_billing_arbiter.sv
// bay_billing_arbiter: per-bay parking-time counters, departure-triggered
// checkout requests and a round-robin grant of the single fee path. A granted
// bill is held on bill_bay/bill_fee until the pay strobe acknowledges it.
// Optional feature macro: PARKING_ALARM_EN adds the BILL timeout counter and
// the ALARM state that drives buz; without it buz is tied low and BILL waits
// for pay indefinitely.
module bay_billing_arbiter #(
    parameter int BAYS    = 8,
    parameter int CNT_W   = 8,
    parameter int RATE    = 2,
    parameter int FEE_W   = 12,
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    bay_billing_if.slave bus
);
    localparam int IDX_W  = $clog2(BAYS);
    localparam int WIDE_W = CNT_W + FEE_W;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [WIDE_W-1:0] FEE_MAX = {{CNT_W{1'b0}}, {FEE_W{1'b1}}};

`ifdef PARKING_ALARM_EN
    typedef enum logic [2:0] {IDLE, GRANT, BILL, ALARM, DONE} state_t;
    localparam int TO_W = $clog2(TIMEOUT + 1);
`else
    typedef enum logic [2:0] {IDLE, GRANT, BILL, DONE} state_t;
`endif

    state_t state;
    state_t state_nxt;

    logic [BAYS-1:0]  occ_q;
    logic [BAYS-1:0]  dep;
    logic [BAYS-1:0]  arr;
    logic [BAYS-1:0]  pending;
    logic [BAYS-1:0]  pending_nxt;
    logic [BAYS-1:0]  in_bill;
    logic [CNT_W-1:0] cnt [BAYS];
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic [IDX_W-1:0] bill_bay;
    logic [FEE_W-1:0] bill_fee;
    logic [3:0]       free_cnt;
    logic             bill_valid_c;
    logic             buz_c;
`ifdef PARKING_ALARM_EN
    logic [TO_W-1:0]  to_cnt;
`endif

    // Fee for a stay of c ticks: at least one RATE unit, clamped to the
    // display width. The product is formed at full width so it cannot wrap.
    function automatic logic [FEE_W-1:0] fee_of(input logic [CNT_W-1:0] c);
        logic [WIDE_W-1:0] wide;
        if (c == '0) begin
            wide = WIDE_W'(RATE);
        end else begin
            wide = WIDE_W'(c) * WIDE_W'(RATE);
        end
        if (wide > FEE_MAX) begin
            wide = FEE_MAX;
        end
        return wide[FEE_W-1:0];
    endfunction

    assign dep = occ_q & ~bus.occ;
    assign arr = ~occ_q & bus.occ;

    // Marks the bay whose bill is currently being presented or retired.
    always_comb begin
        in_bill = '0;
        if (state != IDLE && state != GRANT) begin
            in_bill[bill_bay] = 1'b1;
        end
    end

    // Next pending set: new departures request checkout unless a bill for that
    // bay already exists; DONE retires the bay just paid.
    always_comb begin
        pending_nxt = pending | (dep & ~pending & ~in_bill);
        if (state == DONE) begin
            pending_nxt[bill_bay] = 1'b0;
        end
    end

    // Round-robin search: first pending bay at or after rr, wrapping around.
    always_comb begin
        pick  = rr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < BAYS; k++) begin
            idx = rr + IDX_W'(k);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Vacant-bay count straight from the registered occupancy.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < BAYS; i++) begin
            free_cnt = free_cnt + {3'b000, ~occ_q[i]};
        end
    end

    // Occupancy history and pending requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            pending <= '0;
        end else begin
            occ_q   <= bus.occ;
            pending <= pending_nxt;
        end
    end

    // Per-bay parking timers: DONE clear beats arrival clear beats counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BAYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BAYS; i++) begin
                if (state == DONE && bill_bay == IDX_W'(i)) begin
                    cnt[i] <= '0;
                end else if (arr[i] && !pending[i] && !in_bill[i]) begin
                    cnt[i] <= '0;
                end else if (bus.tick && bus.en && occ_q[i] && !pending_nxt[i]
                             && !in_bill[i] && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and bill/alarm output decode.
    always_comb begin
        state_nxt    = state;
        bill_valid_c = 1'b0;
        buz_c        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && (pending != '0)) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = BILL;
            end
            BILL: begin
                bill_valid_c = 1'b1;
                if (bus.pay) begin
                    state_nxt = DONE;
                end
`ifdef PARKING_ALARM_EN
                else if (bus.tick && (to_cnt == TO_W'(TIMEOUT - 1))) begin
                    state_nxt = ALARM;
                end
            end
            ALARM: begin
                bill_valid_c = 1'b1;
                buz_c        = 1'b1;
                if (bus.pay) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PARKING_ALARM_EN
    // Unpaid-tick counter for the bill on display, restarted at each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == GRANT) begin
            to_cnt <= '0;
        end else if (state == BILL && bus.tick && !bus.pay) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    // Bill latch: bay and fee are captured in GRANT and held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            bill_bay <= '0;
            bill_fee <= '0;
        end else if (state == GRANT) begin
            bill_bay <= pick;
            bill_fee <= fee_of(cnt[pick]);
        end
    end

    // Round-robin pointer moves past the bay just paid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (state == DONE) begin
            rr <= bill_bay + 1'b1;
        end
    end

    assign bus.bill_valid = bill_valid_c;
    assign bus.buz        = buz_c;
    assign bus.bill_bay   = bill_bay;
    assign bus.bill_fee   = bill_fee;
    assign bus.pending    = pending;
    assign bus.free_cnt   = free_cnt;

endmodule

// File: tb/tb_bay_billing_arbiter.sv
// tb_bay_billing_arbiter: table-driven vectors, directed corner sequences and
// randomized traffic for bay_billing_arbiter, all checked against a
// behavioural model of the billing rules.
module tb_bay_billing_arbiter;
    localparam int RATE    = 2;
    localparam int FEE_MAX = 4095;
    localparam int CNT_MAX = 255;
    localparam int TIMEOUT = 16;
`ifdef PARKING_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_GRANT = 1;
    localparam int P_BILL  = 2;
    localparam int P_ALARM = 3;
    localparam int P_DONE  = 4;

    logic clk = 1'b0;
    logic rst;

    bay_billing_if #(.BAYS(8), .FEE_W(12)) bus ();

    bay_billing_arbiter #(
        .BAYS(8), .CNT_W(8), .RATE(RATE), .FEE_W(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [7:0] m_occ_q;
    logic [7:0] m_pend;
    int         m_cnt [8];
    int         m_phase;
    int         m_bay;
    int         m_fee;
    int         m_rr;
    int         m_to;

    typedef struct {
        logic       en;
        logic       tick;
        logic [7:0] occ;
        logic       pay;
        logic       exp_valid;
        int         exp_bay;
        int         exp_fee;
        logic [7:0] exp_pend;
        int         exp_free;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_occ_q = '0;
        m_pend  = '0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_phase = P_IDLE;
        m_bay   = 0;
        m_fee   = 0;
        m_rr    = 0;
        m_to    = 0;
    endfunction

    function automatic void model_update(input logic e, input logic t,
                                         input logic [7:0] o, input logic p);
        logic [7:0] np;
        int old_phase;
        int old_bay;
        int pk;
        old_phase = m_phase;
        old_bay   = m_bay;
        np = m_pend;
        for (int i = 0; i < 8; i++) begin
            if (m_occ_q[i] && !o[i]) np[i] = 1'b1;
        end
        if (old_phase == P_DONE) np[old_bay] = 1'b0;

        case (old_phase)
            P_IDLE: if (e && m_pend != 0) m_phase = P_GRANT;
            P_GRANT: begin
                pk = -1;
                for (int k = 0; k < 8; k++) begin
                    if (pk < 0 && m_pend[(m_rr + k) % 8]) pk = (m_rr + k) % 8;
                end
                if (pk < 0) pk = m_rr;
                m_bay = pk;
                if (m_cnt[pk] == 0) m_fee = RATE;
                else if (m_cnt[pk] * RATE > FEE_MAX) m_fee = FEE_MAX;
                else m_fee = m_cnt[pk] * RATE;
                m_to = 0;
                m_phase = P_BILL;
            end
            P_BILL: begin
                if (p) m_phase = P_DONE;
                else if (ALARM_EN && t) begin
                    m_to++;
                    if (m_to == TIMEOUT) m_phase = P_ALARM;
                end
            end
            P_ALARM: if (p) m_phase = P_DONE;
            default: begin
                m_rr = (old_bay + 1) % 8;
                m_phase = P_IDLE;
            end
        endcase

        for (int i = 0; i < 8; i++) begin
            if (old_phase == P_DONE && old_bay == i) m_cnt[i] = 0;
            else if (!m_occ_q[i] && o[i] && !m_pend[i]) m_cnt[i] = 0;
            else if (t && e && m_occ_q[i] && !np[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
        end
        m_pend  = np;
        m_occ_q = o;
    endfunction

    task automatic compare_model();
        int vac;
        vac = 0;
        for (int i = 0; i < 8; i++) if (!m_occ_q[i]) vac++;
        check("model_valid", bus.bill_valid, (m_phase == P_BILL || m_phase == P_ALARM) ? 1 : 0);
        check("model_buz", bus.buz, (m_phase == P_ALARM) ? 1 : 0);
        check("model_bay", bus.bill_bay, m_bay);
        check("model_fee", bus.bill_fee, m_fee);
        check("model_pending", bus.pending, m_pend);
        check("model_free", bus.free_cnt, vac);
    endtask

    task automatic step(input logic r, input logic e, input logic t,
                        input logic [7:0] o, input logic p);
        rst      = r;
        bus.en   = e;
        bus.tick = t;
        bus.occ  = o;
        bus.pay  = p;
        @(posedge clk);
        if (r) model_reset();
        else model_update(e, t, o, p);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Waits (bounded) for a bill, checks it, pays it and returns to IDLE.
    task automatic run_until_bill(input logic [7:0] o, input int exp_bay, input int exp_fee);
        for (int n = 0; n < 8 && !bus.bill_valid; n++) begin
            step(1'b0, 1'b1, 1'b0, o, 1'b0);
        end
        check("bill_wait", bus.bill_valid, 1);
        check("bill_bay", bus.bill_bay, exp_bay);
        check("bill_fee", bus.bill_fee, exp_fee);
        step(1'b0, 1'b1, 1'b0, o, 1'b1);
        check("paid_valid", bus.bill_valid, 0);
        step(1'b0, 1'b1, 1'b0, o, 1'b0);
        check("paid_pending", bus.pending[exp_bay], 0);
    endtask

    logic [7:0] ro;

    initial begin
        model_reset();
        rst = 1'b1; bus.en = 1'b0; bus.tick = 1'b0; bus.occ = 8'h00; bus.pay = 1'b0;

        vt[0]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 0, 0, 8'h00, 7};
        vt[1]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 0, 0, 8'h00, 7};
        vt[2]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 0, 0, 8'h00, 7};
        vt[3]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 0, 0, 8'h00, 7};
        vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h01, 8};
        vt[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'h01, 8};
        vt[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 4, 8'h01, 8};
        vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 4, 8'h01, 8};
        vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 4, 8'h00, 8};
        vt[9]  = '{1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 0, 4, 8'h00, 7};
        vt[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 4, 8'h10, 8};
        vt[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 4, 8'h10, 8};
        vt[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4, 2, 8'h10, 8};
        vt[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4, 2, 8'h10, 8};
        vt[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4, 2, 8'h00, 8};

        // Reset values
        do_reset();
        check("rst_free", bus.free_cnt, 8);
        check("rst_valid", bus.bill_valid, 0);
        check("rst_buz", bus.buz, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_fee", bus.bill_fee, 0);
        check("rst_bay", bus.bill_bay, 0);

        // Vector table: en=0 tick ignored, 3-cycle latency, zero-tick fee
        for (int i = 0; i < 15; i++) begin
            step(1'b0, vt[i].en, vt[i].tick, vt[i].occ, vt[i].pay);
            check($sformatf("vec%0d_valid", i), bus.bill_valid, vt[i].exp_valid);
            check($sformatf("vec%0d_bay", i), bus.bill_bay, vt[i].exp_bay);
            check($sformatf("vec%0d_fee", i), bus.bill_fee, vt[i].exp_fee);
            check($sformatf("vec%0d_pend", i), bus.pending, vt[i].exp_pend);
            check($sformatf("vec%0d_free", i), bus.free_cnt, vt[i].exp_free);
        end

        // Single bill after 10 ticks
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("single_pending", bus.pending, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("single_grant_valid", bus.bill_valid, 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("single_valid", bus.bill_valid, 1);
        check("single_bay", bus.bill_bay, 0);
        check("single_fee", bus.bill_fee, 20);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("single_pay_valid", bus.bill_valid, 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("single_pay_pending", bus.pending, 0);

        // Round-robin: 2 then 5 from rr=0, then 1 then 3 from rr=6
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h24, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_until_bill(8'h00, 2, 2);
        run_until_bill(8'h00, 5, 2);
        step(1'b0, 1'b1, 1'b0, 8'h0A, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_until_bill(8'h00, 1, 2);
        run_until_bill(8'h00, 3, 2);

        // Counter saturation
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h01, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_until_bill(8'h00, 0, 510);

        // Overdue alarm
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h40, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("alarm_bill_valid", bus.bill_valid, 1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        check("alarm_buz_15", bus.buz, 0);
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        check("alarm_buz_16", bus.buz, ALARM_EN ? 1 : 0);
        check("alarm_valid_16", bus.bill_valid, 1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("alarm_pay_buz", bus.buz, 0);
        check("alarm_pay_valid", bus.bill_valid, 0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Re-departure during BILL of the same bay
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h08, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("redep_bay", bus.bill_bay, 3);
        step(1'b0, 1'b1, 1'b1, 8'h08, 1'b0);
        check("redep_arr_pend", bus.pending, 8'h08);
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        check("redep_dep_pend", bus.pending, 8'h08);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            check("redep_no_rebill", bus.bill_valid, 0);
            check("redep_pend_clear", bus.pending, 0);
        end

        // Reset in the middle of an overdue bill
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h80, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        check("midrst_buz_before", bus.buz, ALARM_EN ? 1 : 0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("midrst_valid", bus.bill_valid, 0);
        check("midrst_buz", bus.buz, 0);
        check("midrst_pending", bus.pending, 0);
        check("midrst_bay", bus.bill_bay, 0);
        check("midrst_fee", bus.bill_fee, 0);
        check("midrst_free", bus.free_cnt, 8);

        // Randomized traffic against the model
        do_reset();
        ro = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) ro = ro ^ (8'h01 << $urandom_range(7));
            step(($urandom_range(499) == 0), ($urandom_range(7) != 0),
                 ($urandom_range(1) == 0), ro, ($urandom_range(7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
